// File: rtl/usb_reg_pkg.sv
// usb_reg_pkg: shared register-map constants, read-bridge FSM states and status bit positions
package usb_reg_pkg;

    localparam logic [7:0] ADDR_FIFO  = 8'd34;
    localparam logic [7:0] ADDR_STAT  = 8'd35;
    localparam logic [7:0] EMPTY_BYTE = 8'h00;

    localparam int STAT_VALID      = 0;
    localparam int STAT_FIFO_EMPTY = 1;
    localparam int STAT_UNDERFLOW  = 2;

    typedef enum logic [1:0] {EMPTY, FETCH, LOAD, FULL} fetch_state_t;

endpackage

// File: rtl/usb_fifo_lane_mux.sv
// usb_fifo_lane_mux: selects one byte lane of the held word, substituting a fixed byte when no word is held
//   word  in  32  held FIFO word (lane 0 = [7:0])
//   lane  in  2   byte lane
//   valid in  1   a word is held
//   data  out 8   selected byte or pEMPTY_BYTE
module usb_fifo_lane_mux
    import usb_reg_pkg::*;
#(
    parameter logic [7:0] pEMPTY_BYTE = EMPTY_BYTE
) (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic        valid,
    output logic [7:0]  data
);

    assign data = valid ? word[{lane, 3'b000} +: 8] : pEMPTY_BYTE;

endmodule

// File: rtl/usb_fifo_rd_bridge.sv
// usb_fifo_rd_bridge: serves bytes of a prefetched 32-bit capture-FIFO word to the USB register front end
//   cwusb_clk, reset (async, active high)
//   reg_address/reg_bytecnt/reg_addrvalid/reg_read/reg_write/reg_datao : front-end register bus
//   reg_datai  out 8   read data (combinational)
//   fifo_dout/fifo_empty in, fifo_rd_en out : capture FIFO read side
//   underflow  out 1   sticky, data port read with no word held
//   Optional USB_FIFO_RD_STATS_EN: words_consumed counter readable at the status address
module usb_fifo_rd_bridge
    import usb_reg_pkg::*;
#(
    parameter int         pBYTECNT_SIZE = 7,
    parameter logic [7:0] pADDR_FIFO    = ADDR_FIFO,
    parameter logic [7:0] pADDR_STAT    = ADDR_STAT,
    parameter logic [7:0] pEMPTY_BYTE   = EMPTY_BYTE
) (
    input  logic                     cwusb_clk,
    input  logic                     reset,
    input  logic [7:0]               reg_address,
    input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    input  logic                     reg_addrvalid,
    input  logic                     reg_read,
    input  logic                     reg_write,
    input  logic [7:0]               reg_datao,
    output logic [7:0]               reg_datai,
    input  logic [31:0]              fifo_dout,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    output logic                     underflow
);

    fetch_state_t state;
    logic [31:0]  word_q;
    logic [1:0]   lane_q;
    logic [1:0]   lane;
    logic         valid;
    logic         reg_read_q;
    logic         rd_rise;
    logic         rd_fall;
    logic         at_fifo;
    logic         at_stat;
    logic         flush;
    logic         consume;
    logic [7:0]   fifo_byte;
    logic [7:0]   stat_byte;
    logic [7:0]   stat_rd;
    logic         unused_bits;

    assign rd_rise = reg_read & ~reg_read_q;
    assign rd_fall = ~reg_read & reg_read_q;
    assign at_fifo = reg_address == pADDR_FIFO;
    assign at_stat = reg_address == pADDR_STAT;
    assign flush   = reg_write & at_stat & reg_datao[0];
    assign consume = rd_fall & at_fifo & reg_addrvalid & valid & (lane_q == 2'd3);
    // bypass the lane register in the rising cycle so data is ready one clock after the read starts
    assign lane    = rd_rise ? reg_bytecnt[1:0] : lane_q;
    assign unused_bits = ^{reg_bytecnt[pBYTECNT_SIZE-1:2], reg_datao[7:1]};

    always_ff @(posedge cwusb_clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            word_q     <= '0;
            lane_q     <= '0;
            valid      <= 1'b0;
            underflow  <= 1'b0;
            fifo_rd_en <= 1'b0;
            reg_read_q <= 1'b0;
        end else begin
            reg_read_q <= reg_read;
            fifo_rd_en <= 1'b0;
            if (rd_rise)
                lane_q <= reg_bytecnt[1:0];
            if (rd_rise & at_fifo & reg_addrvalid & ~valid)
                underflow <= 1'b1;
            case (state)
                EMPTY: if (!fifo_empty && !reg_read) begin
                    state      <= FETCH;
                    fifo_rd_en <= 1'b1;
                end
                FETCH: state <= LOAD;
                // the FIFO holds fifo_dout until the next pop, so the load may wait out an active read
                LOAD: if (!reg_read) begin
                    word_q <= fifo_dout;
                    valid  <= 1'b1;
                    state  <= FULL;
                end
                FULL: if (consume) begin
                    valid <= 1'b0;
                    state <= EMPTY;
                end
                default: state <= EMPTY;
            endcase
            if (flush) begin
                valid     <= 1'b0;
                underflow <= 1'b0;
                if (state inside {LOAD, FULL})
                    state <= EMPTY;
            end
        end
    end

    always_comb begin
        stat_byte                  = 8'h00;
        stat_byte[STAT_VALID]      = valid;
        stat_byte[STAT_FIFO_EMPTY] = fifo_empty;
        stat_byte[STAT_UNDERFLOW]  = underflow;
    end

`ifdef USB_FIFO_RD_STATS_EN
    logic [15:0] words_consumed;

    always_ff @(posedge cwusb_clk or posedge reset) begin
        if (reset)
            words_consumed <= '0;
        else if (flush)
            words_consumed <= '0;
        else if (consume)
            words_consumed <= words_consumed + 16'd1;
    end

    assign stat_rd = lane == 2'd0 ? stat_byte :
                     lane == 2'd1 ? words_consumed[7:0] :
                     lane == 2'd2 ? words_consumed[15:8] : 8'h00;
`else
    assign stat_rd = stat_byte;
`endif

    usb_fifo_lane_mux #(
        .pEMPTY_BYTE (pEMPTY_BYTE)
    ) u_lane_mux (
        .word  (word_q),
        .lane  (lane),
        .valid (valid),
        .data  (fifo_byte)
    );

    assign reg_datai = at_fifo ? fifo_byte : at_stat ? stat_rd : 8'h00;

endmodule

// File: tb/tb_usb_fifo_rd_bridge.sv
// tb_usb_fifo_rd_bridge: randomized bench for usb_fifo_rd_bridge against a transaction-level model
module tb_usb_fifo_rd_bridge;
    import usb_reg_pkg::*;

    localparam int GAP   = 6;
    localparam int DEPTH = 1024;

    logic        cwusb_clk;
    logic        reset;
    logic [7:0]  reg_address;
    logic [6:0]  reg_bytecnt;
    logic        reg_addrvalid;
    logic        reg_read;
    logic        reg_write;
    logic [7:0]  reg_datao;
    logic [7:0]  reg_datai;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        underflow;

    usb_fifo_rd_bridge dut (
        .cwusb_clk     (cwusb_clk),
        .reset         (reset),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .reg_addrvalid (reg_addrvalid),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_datao     (reg_datao),
        .reg_datai     (reg_datai),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .underflow     (underflow)
    );

    initial cwusb_clk = 1'b0;
    always #5 cwusb_clk = ~cwusb_clk;

    int n_total = 0;
    int n_pass  = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    // capture FIFO: initial block owns the write side, the pop process owns the read side
    logic [31:0] fifo_mem [DEPTH];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    initial fifo_dout = '0;
    always @(negedge cwusb_clk) begin
        if (fifo_rd_en) begin
            check("pop_when_empty", {31'd0, fifo_empty}, 32'd0);
            fifo_dout = fifo_mem[rd_ptr % DEPTH];
            rd_ptr++;
        end
    end

    // transaction-level model: FIFO contents, the held word, sticky underflow, consume count
    logic [31:0] mq [$];
    logic [31:0] mheld = '0;
    bit          mheld_v = 0;
    bit          munder = 0;
    int          mcnt = 0;
    int          mpops = 0;
    int          pop_base = 0;

    // expectation handed to the compare process one clock after each read starts
    logic [7:0]  exp_data;
    logic        exp_under;
    string       exp_name;
    int          exp_seq = 0;
    int          seen_seq = 0;

    always @(posedge cwusb_clk) begin
        #1;
        if (exp_seq != seen_seq) begin
            seen_seq = exp_seq;
            check(exp_name, {24'd0, reg_datai}, {24'd0, exp_data});
            check({exp_name, "_underflow"}, {31'd0, underflow}, {31'd0, exp_under});
        end
    end

    task automatic push(input logic [31:0] w);
        fifo_mem[wr_ptr % DEPTH] = w;
        wr_ptr++;
        mq.push_back(w);
    endtask

    task automatic idle();
        repeat (GAP) @(negedge cwusb_clk);
        if (!mheld_v && mq.size() > 0) begin
            mheld   = mq.pop_front();
            mheld_v = 1;
            mpops++;
        end
        check("pop_count", rd_ptr - pop_base, mpops);
    endtask

    task automatic rd(input logic [7:0] a, input int bc, output logic [7:0] got);
        logic [1:0] ln;
        logic [7:0] st;
        ln = bc[1:0];
        if (a == ADDR_FIFO) begin
            exp_name = "fifo_byte";
            if (mheld_v) begin
                exp_data = mheld[8*ln +: 8];
                if (ln == 2'd3) begin
                    mheld_v = 0;
                    mcnt++;
                end
            end else begin
                exp_data = 8'h00;
                munder   = 1;
            end
        end else if (a == ADDR_STAT) begin
            exp_name = "stat_byte";
            st = {5'd0, munder, mq.size() == 0, mheld_v};
`ifdef USB_FIFO_RD_STATS_EN
            exp_data = ln == 2'd0 ? st : ln == 2'd1 ? mcnt[7:0] : ln == 2'd2 ? mcnt[15:8] : 8'h00;
`else
            exp_data = st;
`endif
        end else begin
            exp_name = "other_addr";
            exp_data = 8'h00;
        end
        exp_under = munder;
        @(negedge cwusb_clk);
        reg_address   = a;
        reg_addrvalid = 1'b1;
        reg_bytecnt   = 7'(bc);
        reg_read      = 1'b1;
        exp_seq++;
        @(negedge cwusb_clk);
        got      = reg_datai;
        reg_read = 1'b0;
        @(negedge cwusb_clk);
        reg_addrvalid = 1'b0;
        idle();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge cwusb_clk);
        reg_address   = a;
        reg_addrvalid = 1'b1;
        reg_datao     = d;
        reg_write     = 1'b1;
        @(negedge cwusb_clk);
        reg_write     = 1'b0;
        reg_addrvalid = 1'b0;
        if (a == ADDR_STAT && d[0]) begin
            mheld_v = 0;
            munder  = 0;
            mcnt    = 0;
        end
    endtask

    task automatic wait_fetch(input int bound, output bit seen);
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge cwusb_clk);
            #1;
            seen = fifo_rd_en;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  got;
        logic [31:0] w;
        bit          seen;
        int          op;
        reset         = 1'b1;
        reg_address   = 8'h00;
        reg_bytecnt   = '0;
        reg_addrvalid = 1'b0;
        reg_read      = 1'b0;
        reg_write     = 1'b0;
        reg_datao     = 8'h00;
        repeat (2) @(negedge cwusb_clk);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_underflow", {31'd0, underflow}, 32'd0);
        reg_address = ADDR_FIFO;
        #1 check("rst_fifo_byte", {24'd0, reg_datai}, 32'h00);
        reg_address = ADDR_STAT;
        #1 check("rst_stat", {24'd0, reg_datai}, 32'h02);
        @(negedge cwusb_clk);
        reset = 1'b0;

        // single word served lane by lane
        push(32'hDDCCBBAA);
        idle();
        rd(ADDR_FIFO, 0, got); check("t1_b0", {24'd0, got}, 32'hAA);
        rd(ADDR_FIFO, 1, got); check("t1_b1", {24'd0, got}, 32'hBB);
        rd(ADDR_FIFO, 2, got); check("t1_b2", {24'd0, got}, 32'hCC);
        rd(ADDR_FIFO, 3, got); check("t1_b3", {24'd0, got}, 32'hDD);
        check("t1_pops", rd_ptr - pop_base, 32'd1);

        // underflow on an empty data port
        rd(ADDR_FIFO, 0, got); check("t2_empty_byte", {24'd0, got}, 32'h00);
        check("t2_underflow", {31'd0, underflow}, 32'd1);
        rd(ADDR_STAT, 0, got); check("t2_stat", {24'd0, got}, 32'h06);

        // eight-byte burst over two words, bytecnt wrapping past 3
        push(32'h44332211);
        push(32'h88776655);
        idle();
        for (int i = 0; i < 8; i++) begin
            rd(ADDR_FIFO, i, got);
            check("t3_burst", {24'd0, got}, 32'(8'h11 * (i + 1)));
        end
        check("t3_pops", rd_ptr - pop_base, 32'd3);

        // flush discards the held word and refetches at once
        push(32'h0A0B0C0D);
        push(32'h1A1B1C1D);
        idle();
        wr(ADDR_STAT, 8'h01);
        check("t4_underflow_clr", {31'd0, underflow}, 32'd0);
        wait_fetch(4, seen);
        check("t4_refetch", {31'd0, seen}, 32'd1);
        idle();
        rd(ADDR_FIFO, 0, got); check("t4_b0", {24'd0, got}, 32'h1D);
        rd(ADDR_FIFO, 3, got); check("t4_b3", {24'd0, got}, 32'h1A);

        // reset while a fetch is in flight
        push(32'h5555AAAA);
        wait_fetch(8, seen);
        check("t5_fetch_seen", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("t5_underflow", {31'd0, underflow}, 32'd0);
        reg_address = ADDR_FIFO;
        #1 check("t5_fifo_byte", {24'd0, reg_datai}, 32'h00);
        reg_address = ADDR_STAT;
        reg_bytecnt = '0;
        #1 check("t5_stat", {24'd0, reg_datai}, 32'h02);
        @(negedge cwusb_clk);
        reset = 1'b0;
        mq.delete();
        mheld_v  = 0;
        munder   = 0;
        mcnt     = 0;
        mpops    = 0;
        pop_base = rd_ptr;
        idle();

        // three consumed words reported through the status register
        for (int i = 0; i < 3; i++) push(32'hC0DE0000 + 32'(i));
        idle();
        for (int i = 0; i < 3; i++) rd(ADDR_FIFO, 3, got);
`ifdef USB_FIFO_RD_STATS_EN
        rd(ADDR_STAT, 1, got); check("t6_cnt_lo", {24'd0, got}, 32'h03);
        rd(ADDR_STAT, 2, got); check("t6_cnt_hi", {24'd0, got}, 32'h00);
`else
        rd(ADDR_STAT, 1, got); check("t6_stat_b1", {24'd0, got}, 32'h02);
        rd(ADDR_STAT, 2, got); check("t6_stat_b2", {24'd0, got}, 32'h02);
`endif

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 1) begin
                if (wr_ptr - rd_ptr < DEPTH - 4)
                    for (int k = 0; k <= int'($urandom_range(0, 1)); k++) push($urandom);
                idle();
            end else if (op <= 5) rd(ADDR_FIFO, $urandom_range(0, 7), got);
            else if (op == 6) rd(ADDR_STAT, $urandom_range(0, 7), got);
            else if (op == 7) begin
                w = $urandom;
                wr(ADDR_STAT, w[7:0]);
                idle();
            end else if (op == 8) begin
                w = $urandom;
                wr(ADDR_FIFO, w[7:0]);
                idle();
            end else begin
                w = 32'($urandom_range(0, 3));
                rd(w == 0 ? 8'd0 : w == 1 ? 8'd33 : w == 2 ? 8'd36 : 8'd200, $urandom_range(0, 7), got);
            end
        end

        repeat (4) @(negedge cwusb_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
